// File: rtl/fifo_dpram.sv
// Dual-port storage array for the asynchronous FIFO: synchronous write on wclk,
// combinational read. Pointer, flag and synchronizer logic live outside this block.
module fifo_dpram #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 4
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                w_en,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);

    localparam int DEPTH = 1 << ADDRSIZE;

    logic [DATASIZE-1:0] mem [DEPTH];

    // Reset clears every entry and wins over a write presented in the same cycle.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            mem <= '{default: '0};
        end else if (w_en) begin
            mem[waddr] <= wdata;
        end
    end

    // No bypass: a same-address write becomes visible only after the edge.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: tb/tb_fifo_dpram.sv
// Directed self-checking bench for fifo_dpram: reset clearing, writes, read-during-write,
// write disable, full-depth wrap and reset priority.
module tb_fifo_dpram;

    localparam int DATASIZE = 8;
    localparam int ADDRSIZE = 4;
    localparam int DEPTH    = 1 << ADDRSIZE;

    logic                wclk;
    logic                wrst;
    logic                w_en;
    logic [ADDRSIZE-1:0] waddr;
    logic [DATASIZE-1:0] wdata;
    logic [ADDRSIZE-1:0] raddr;
    logic [DATASIZE-1:0] rdata;

    int n_checks;
    int n_fail;

    fifo_dpram #(
        .DATASIZE(DATASIZE),
        .ADDRSIZE(ADDRSIZE)
    ) dut (
        .wclk (wclk),
        .wrst (wrst),
        .w_en (w_en),
        .waddr(waddr),
        .wdata(wdata),
        .raddr(raddr),
        .rdata(rdata)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Advance one rising edge and settle 1 ns past it before sampling or driving.
    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_pre_reset_write();
        wrst  = 1'b0;
        w_en  = 1'b1;
        waddr = 4'd7;
        wdata = 8'hA5;
        tick();
        w_en  = 1'b0;
        raddr = 4'd7;
        #1;
        n_checks++;
        if (rdata !== 8'hA5) begin
            n_fail++;
            $display("FAIL pre_reset_write: rdata=%0h expected a5", rdata);
        end
    endtask

    task automatic test_reset();
        wrst = 1'b1;
        w_en = 1'b0;
        tick();
        wrst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            raddr = ADDRSIZE'(i);
            #1;
            n_checks++;
            if (rdata !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_clear addr %0d: rdata=%0d expected 0", i, rdata);
            end
        end
    endtask

    task automatic test_sequential_writes();
        for (int i = 0; i < 5; i++) begin
            w_en  = 1'b1;
            waddr = ADDRSIZE'(i);
            wdata = DATASIZE'(5 * (i + 1));
            tick();
        end
        w_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            raddr = ADDRSIZE'(i);
            #1;
            n_checks++;
            if (rdata !== DATASIZE'(5 * (i + 1))) begin
                n_fail++;
                $display("FAIL seq_write addr %0d: rdata=%0d expected %0d", i, rdata, 5 * (i + 1));
            end
        end
    endtask

    task automatic test_read_during_write();
        raddr = 4'd2;
        waddr = 4'd2;
        wdata = 8'd99;
        w_en  = 1'b1;
        #1;
        n_checks++;
        if (rdata !== 8'd15) begin
            n_fail++;
            $display("FAIL rdw_before_edge: rdata=%0d expected 15", rdata);
        end
        tick();
        w_en = 1'b0;
        n_checks++;
        if (rdata !== 8'd99) begin
            n_fail++;
            $display("FAIL rdw_after_edge: rdata=%0d expected 99", rdata);
        end
    endtask

    task automatic test_write_disable();
        w_en  = 1'b0;
        waddr = 4'd1;
        wdata = 8'd77;
        repeat (3) tick();
        raddr = 4'd1;
        #1;
        n_checks++;
        if (rdata !== 8'd10) begin
            n_fail++;
            $display("FAIL write_disable: rdata=%0d expected 10", rdata);
        end
    endtask

    task automatic test_independent_ports();
        raddr = 4'd3;
        waddr = 4'd4;
        wdata = 8'd44;
        w_en  = 1'b1;
        #1;
        n_checks++;
        if (rdata !== 8'd20) begin
            n_fail++;
            $display("FAIL indep_before_edge: rdata=%0d expected 20", rdata);
        end
        tick();
        w_en = 1'b0;
        n_checks++;
        if (rdata !== 8'd20) begin
            n_fail++;
            $display("FAIL indep_after_edge: rdata=%0d expected 20", rdata);
        end
        raddr = 4'd4;
        #1;
        n_checks++;
        if (rdata !== 8'd44) begin
            n_fail++;
            $display("FAIL indep_written: rdata=%0d expected 44", rdata);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < DEPTH; i++) begin
            w_en  = 1'b1;
            waddr = ADDRSIZE'(i);
            wdata = DATASIZE'(100 + i);
            tick();
        end
        waddr = 4'd0;
        wdata = 8'd200;
        tick();
        w_en = 1'b0;
        raddr = 4'd0;
        #1;
        n_checks++;
        if (rdata !== 8'd200) begin
            n_fail++;
            $display("FAIL wrap_addr0: rdata=%0d expected 200", rdata);
        end
        raddr = 4'd8;
        #1;
        n_checks++;
        if (rdata !== 8'd108) begin
            n_fail++;
            $display("FAIL wrap_addr8: rdata=%0d expected 108", rdata);
        end
        raddr = 4'd15;
        #1;
        n_checks++;
        if (rdata !== 8'd115) begin
            n_fail++;
            $display("FAIL wrap_addr15: rdata=%0d expected 115", rdata);
        end
    endtask

    task automatic test_reset_priority();
        wrst  = 1'b1;
        w_en  = 1'b1;
        waddr = 4'd3;
        wdata = 8'd55;
        tick();
        wrst  = 1'b0;
        w_en  = 1'b0;
        raddr = 4'd3;
        #1;
        n_checks++;
        if (rdata !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_priority_addr3: rdata=%0d expected 0", rdata);
        end
        raddr = 4'd15;
        #1;
        n_checks++;
        if (rdata !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_midop_addr15: rdata=%0d expected 0", rdata);
        end
        w_en  = 1'b1;
        raddr = 4'd3;
        tick();
        w_en = 1'b0;
        n_checks++;
        if (rdata !== 8'd55) begin
            n_fail++;
            $display("FAIL post_reset_write: rdata=%0d expected 55", rdata);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        wrst  = 1'b0;
        w_en  = 1'b0;
        waddr = '0;
        wdata = '0;
        raddr = '0;
        #2;
        test_pre_reset_write();
        test_reset();
        test_sequential_writes();
        test_read_during_write();
        test_write_disable();
        test_independent_ports();
        test_wrap();
        test_reset_priority();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_dpram.md
Name: fifo_dpram

Overview:
- Storage array for the asynchronous FIFO: a 2^ADDRSIZE x DATASIZE dual-port RAM.
- Write port is synchronous to wclk; read port is an asynchronous (combinational) lookup.
- Pointer, flag and synchronizer logic are external. This block only stores data at the addresses it is given and returns data at the addresses it is given.

Parameters:
- DATASIZE, 8, width of each data word in bits.
- ADDRSIZE, 4, address width in bits; depth is DEPTH = 2^ADDRSIZE (16 by default).

Ports:
- wclk  input  1  write clock, the single clock of the block; all state updates occur on its rising edge.
- wrst  input  1  reset, synchronous and active-high.
- w_en  input  1  write enable, sampled on the rising edge of wclk.
- waddr  input  ADDRSIZE  write address.
- wdata  input  DATASIZE  write data.
- raddr  input  ADDRSIZE  read address.
- rdata  output  DATASIZE  read data, combinational from raddr and array contents.

Behaviour:
- Array: DEPTH entries of DATASIZE bits. Every address value is valid; there is no out-of-range case.
- Write: on the rising edge of wclk, with wrst=0 and w_en=1, mem[waddr] <= wdata. With w_en=0, no entry changes.
- Read: rdata = mem[raddr] continuously, with zero-cycle latency.
  - A change on raddr is reflected on rdata in the same delta/cycle, with no clock needed.
  - After a write edge, rdata reflects the new contents immediately if raddr matches the written address.
- Read-during-write to the same address:
  - Before the edge, rdata shows the old word.
  - After the edge, rdata shows the new word.
  - No bypass of wdata before the edge.
- Reset:
  - On a rising edge of wclk with wrst=1, all DEPTH entries are cleared to 0.
  - Reset has priority over w_en: a write presented in the reset cycle is discarded.
  - From that edge onward, rdata = 0 for every raddr until a write occurs.
- Reset mid-operation: same as above, with previous contents lost. The first write after wrst deasserts lands normally on the next edge.
- Before the first reset:
  - Contents are undefined (X in simulation).
  - Writes still function; a written entry reads back correctly even without a prior reset.
- No full/empty protection inside the block:
  - Overwriting an unread entry is the caller's responsibility.
  - Wrap-around is implicit, since addresses are modulo DEPTH.
- Simultaneous w_en=1 with waddr != raddr: write and read are independent. rdata stays mem[raddr] and is unaffected by the write.
- Output has no register and no reset value of its own. Its value after reset follows from the cleared array (0).

Test Plan:
- Reset then readback: wrst=1 for one wclk edge, then sweep raddr 0..15 -> rdata=0 at every address.
- Sequential writes: w_en=1 with (addr0,5), (addr1,10), (addr2,15), (addr3,20), (addr4,25) on consecutive edges, then read addresses 0..4 -> rdata = 5, 10, 15, 20, 25 respectively.
- Read-during-write same address: raddr=waddr=2, old value 15, write 99 -> rdata=15 before the edge and 99 immediately after it.
- Write disable: after the sequential writes, w_en=0 with wdata=77, waddr=1 for several edges -> mem[1] still reads 10.
- Wrap/full depth: write value 100+i to addr i for i=0..15, then write 200 to addr 0 -> reading addr 0 gives 200, addr 15 gives 115.
- Reset priority: wrst=1 and w_en=1 (addr 3, data 55) on the same edge -> addr 3 reads 0. The next edge with wrst=0 and the same write -> addr 3 reads 55.
